// File: rtl/avg_pipe_n.sv
// avg_pipe_n: pipelined NUM_IN-input unsigned averager, registered adder tree + constant divide,
// global-stall valid/ready. Define AVG_ROUND_EN for a round-half-up divide instead of truncation.
module avg_pipe_n #(
    parameter int  WIDTH  = 8,
    parameter int  NUM_IN = 3,
    localparam int SUM_W  = WIDTH + $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_avg,
    output logic [SUM_W-1:0]        out_sum,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int S   = $clog2(NUM_IN);
    localparam int LAT = S + 1;

    if (NUM_IN < 2 || NUM_IN > 16 || WIDTH < 1 || WIDTH > 32) begin : g_bad_cfg
        $error("avg_pipe_n: WIDTH must be 1..32 and NUM_IN 2..16");
    end

    // Operand count at tree level l; an odd leftover rides along unchanged.
    function automatic int lvl_cnt(input int l);
        int c;
        c = NUM_IN;
        for (int k = 0; k < l; k++) c = (c + 1) / 2;
        return c;
    endfunction

    logic           stall;
    logic           adv;
    logic [LAT-1:0] vld_pipe_q;
    logic [LAT-1:0] vld_pipe_d;

    assign stall     = vld_pipe_q[LAT-1] & ~out_ready;
    assign adv       = ~stall;
    assign in_ready  = ~stall;
    assign out_valid = vld_pipe_q[LAT-1];

    genvar l, j;
    for (l = 0; l <= S; l++) begin : g_lvl
        localparam int CNT = lvl_cnt(l);
        localparam int NW  = WIDTH + l;
        logic [CNT-1:0][NW-1:0] node;

        if (l == 0) begin : g_in
            assign node = in_data;
        end else begin : g_add
            localparam int PCNT = lvl_cnt(l - 1);
            logic [CNT-1:0][NW-1:0] node_d;

            for (j = 0; j < CNT; j++) begin : g_n
                if (2 * j + 1 < PCNT) begin : g_pair
                    assign node_d[j] = {1'b0, g_lvl[l-1].node[2*j]} + {1'b0, g_lvl[l-1].node[2*j+1]};
                end else begin : g_pass
                    assign node_d[j] = {1'b0, g_lvl[l-1].node[2*j]};
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)   node <= '0;
                else if (adv) node <= node_d;
            end
        end
    end

    logic [SUM_W-1:0] sum_w;
    logic [WIDTH-1:0] avg_d;
    logic [WIDTH-1:0] avg_q;
    logic [SUM_W-1:0] sum_q;

    assign sum_w = g_lvl[S].node[0];

`ifdef AVG_ROUND_EN
    // One extra bit keeps sum + NUM_IN/2 from wrapping at full-scale inputs.
    logic [SUM_W:0] rnd_w;
    assign rnd_w = {1'b0, sum_w} + (SUM_W+1)'(NUM_IN / 2);
    assign avg_d = WIDTH'(rnd_w / (SUM_W+1)'(NUM_IN));
`else
    assign avg_d = WIDTH'(sum_w / SUM_W'(NUM_IN));
`endif

    assign vld_pipe_d = {vld_pipe_q[LAT-2:0], in_valid};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_q <= '0;
            avg_q      <= '0;
            sum_q      <= '0;
        end else if (adv) begin
            vld_pipe_q <= vld_pipe_d;
            avg_q      <= avg_d;
            sum_q      <= sum_w;
        end
    end

    assign out_avg = avg_q;
    assign out_sum = sum_q;

endmodule

// File: tb/tb_avg_pipe_n.sv
// Directed bench for avg_pipe_n: default 3x8 instance plus a 5x12 instance.
module tb_avg_pipe_n;

`ifdef AVG_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [23:0] a_data;
    logic        a_iv, a_ir, a_ov, a_or;
    logic [7:0]  a_avg;
    logic [9:0]  a_sum;

    logic [59:0] b_data;
    logic        b_iv, b_ir, b_ov, b_or;
    logic [11:0] b_avg;
    logic [14:0] b_sum;

    avg_pipe_n #(.WIDTH(8), .NUM_IN(3)) u_a (
        .clk(clk), .rst_n(rst_n), .in_data(a_data), .in_valid(a_iv), .in_ready(a_ir),
        .out_avg(a_avg), .out_sum(a_sum), .out_valid(a_ov), .out_ready(a_or)
    );

    avg_pipe_n #(.WIDTH(12), .NUM_IN(5)) u_b (
        .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_valid(b_iv), .in_ready(b_ir),
        .out_avg(b_avg), .out_sum(b_sum), .out_valid(b_ov), .out_ready(b_or)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    task automatic run_a(input string tag, input logic [7:0] s0, input logic [7:0] s1,
                         input logic [7:0] s2, input int e_avg, input int e_sum);
        int cnt;
        @(negedge clk);
        a_data = {s2, s1, s0};
        a_iv   = 1'b1;
        @(negedge clk);
        a_iv = 1'b0;
        cnt  = 1;
        while (!a_ov && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk({tag, "_lat"}, cnt, 3);
        chk({tag, "_avg"}, a_avg, e_avg);
        chk({tag, "_sum"}, a_sum, e_sum);
        @(negedge clk);
        chk({tag, "_pulse"}, a_ov, 0);
    endtask

    task automatic run_b(input string tag, input logic [59:0] d, input int e_avg, input int e_sum);
        int cnt;
        @(negedge clk);
        b_data = d;
        b_iv   = 1'b1;
        @(negedge clk);
        b_iv = 1'b0;
        cnt  = 1;
        while (!b_ov && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk({tag, "_lat"}, cnt, 4);
        chk({tag, "_avg"}, b_avg, e_avg);
        chk({tag, "_sum"}, b_sum, e_sum);
        @(negedge clk);
        chk({tag, "_pulse"}, b_ov, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int got, first, last;
        a_data = '0; a_iv = 1'b0; a_or = 1'b1;
        b_data = '0; b_iv = 1'b0; b_or = 1'b1;

        #12;
        chk("rst_a_vld", a_ov, 0);
        chk("rst_a_rdy", a_ir, 1);
        chk("rst_a_avg", a_avg, 0);
        chk("rst_a_sum", a_sum, 0);
        chk("rst_b_vld", b_ov, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_a("v102030", 8'd10, 8'd20, 8'd30, 20, 60);
        run_a("vmax", 8'd255, 8'd255, 8'd255, 255, 765);
        run_a("v122", 8'd1, 8'd2, 8'd2, RND ? 2 : 1, 5);
        run_a("v112", 8'd1, 8'd1, 8'd2, 1, 4);

        run_b("b_max", {5{12'd4095}}, 4095, 20475);
        run_b("b_10001", {12'd1, 12'd0, 12'd0, 12'd0, 12'd1}, 0, 2);

        // Back-to-back: vector c = (c, c, c+3), sum 3c+3, avg c+1.
        got = 0; first = -1; last = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (a_ov) begin
                chk("b2b_sum", a_sum, 3 * got + 3);
                chk("b2b_avg", a_avg, got + 1);
                if (first < 0) first = c;
                last = c;
                got++;
            end
            if (c < 10) begin
                chk("b2b_rdy", a_ir, 1);
                a_data = {8'(c + 3), 8'(c), 8'(c)};
                a_iv   = 1'b1;
            end else begin
                a_iv = 1'b0;
            end
        end
        chk("b2b_cnt", got, 10);
        chk("b2b_run", last - first, 9);

        // Backpressure with (3,3,3) then (6,6,6); junk offered while stalled.
        @(negedge clk);
        a_data = {3{8'd3}}; a_iv = 1'b1;
        @(negedge clk);
        a_data = {3{8'd6}};
        @(negedge clk);
        a_iv = 1'b0; a_or = 1'b0;
        @(negedge clk);
        chk("bp_vld", a_ov, 1);
        chk("bp_avg", a_avg, 3);
        chk("bp_sum", a_sum, 9);
        chk("bp_rdy", a_ir, 0);
        a_data = {3{8'd9}}; a_iv = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("bp_hold_vld", a_ov, 1);
            chk("bp_hold_avg", a_avg, 3);
            chk("bp_hold_rdy", a_ir, 0);
        end
        a_or = 1'b1; a_iv = 1'b0;
        #1;
        chk("bp_rel_rdy", a_ir, 1);
        @(negedge clk);
        chk("bp_2nd_vld", a_ov, 1);
        chk("bp_2nd_avg", a_avg, 6);
        chk("bp_2nd_sum", a_sum, 18);
        repeat (3) begin
            @(negedge clk);
            chk("bp_tail", a_ov, 0);
        end

        // Reset with data in flight.
        @(negedge clk);
        a_data = {3{8'd100}}; a_iv = 1'b1;
        @(negedge clk);
        a_data = {3{8'd50}};
        @(negedge clk);
        a_iv = 1'b0;
        @(negedge clk);
        chk("rs_pre_vld", a_ov, 1);
        chk("rs_pre_avg", a_avg, 100);
        #1 rst_n = 1'b0;
        #1;
        chk("rs_vld", a_ov, 0);
        chk("rs_avg", a_avg, 0);
        chk("rs_sum", a_sum, 0);
        chk("rs_rdy", a_ir, 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("rs_stale", a_ov, 0);
        end
        run_a("v789", 8'd7, 8'd8, 8'd9, 8, 24);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
